// File: rtl/rgmii_delay_cal_if.sv
// Calibration handshake and tap bus between the RGMII delay calibrator and its
// surroundings; master is the calibrator, slave is the IO-delay/MAC side.
interface rgmii_delay_cal_if;
    logic       cal_start;
    logic       pattern_ok;
    logic [4:0] delay_set;
    logic [4:0] delay_set_rb;
    logic       busy;
    logic       cal_done;
    logic       cal_fail;
    logic [4:0] win_start;
    logic [5:0] win_len;

    modport master (
        input  cal_start, pattern_ok, delay_set_rb,
        output delay_set, busy, cal_done, cal_fail, win_start, win_len
    );

    modport slave (
        output cal_start, pattern_ok, delay_set_rb,
        input  delay_set, busy, cal_done, cal_fail, win_start, win_len
    );
endinterface

// File: rtl/rgmii_delay_cal.sv
// RGMII receive delay calibrator: sweeps 32 taps, finds the longest passing window
// and parks at its centre. Define RGMII_DELAY_CAL_RDBK_CHECK_EN for tap readback checking.
module rgmii_delay_cal #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLE_CYCLES = 64,
    parameter logic [4:0]  DEFAULT_TAP   = 5'd0
) (
    input  logic              delay_clk,
    input  logic              delay_rst,
    rgmii_delay_cal_if.master bus
);

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
    localparam logic [9:0] SAMPLE_LAST = 10'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_CENTER, S_DONE, S_FAIL
    } state_t;

    state_t     state_q;
    logic [4:0] tap_q;
    logic [9:0] cyc_q;
    logic       tap_fail_q;
    logic [4:0] run_start_q, best_start_q, run_start_d, best_start_d;
    logic [5:0] run_len_q, best_len_q, run_len_d, best_len_d;
    logic [4:0] delay_set_q, win_start_q;
    logic [5:0] win_len_q;
    logic       busy_q, done_q, fail_q;
    logic [4:0] center_tap;

    // Run/best update for the tap just sampled, including the closing compare at tap 31.
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (!tap_fail_q) begin
            if (run_len_q == 6'd0) run_start_d = tap_q;
            run_len_d = run_len_q + 6'd1;
        end else begin
            if (run_len_q > best_len_q) begin
                best_start_d = run_start_q;
                best_len_d   = run_len_q;
            end
            run_len_d = 6'd0;
        end
        if (tap_q == 5'd31 && run_len_d > best_len_d) begin
            best_start_d = run_start_d;
            best_len_d   = run_len_d;
        end
    end

    assign center_tap = 5'(6'(best_start_q) + (best_len_q >> 1));

`ifndef RGMII_DELAY_CAL_RDBK_CHECK_EN
    logic unused_rb;
    assign unused_rb = ^bus.delay_set_rb;
`endif

    always_ff @(posedge delay_clk) begin
        if (delay_rst) begin
            state_q      <= S_IDLE;
            tap_q        <= 5'd0;
            cyc_q        <= 10'd0;
            tap_fail_q   <= 1'b0;
            run_start_q  <= 5'd0;
            run_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            delay_set_q  <= DEFAULT_TAP;
            win_start_q  <= 5'd0;
            win_len_q    <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (bus.cal_start) begin
                        run_start_q  <= 5'd0;
                        run_len_q    <= 6'd0;
                        best_start_q <= 5'd0;
                        best_len_q   <= 6'd0;
                        tap_q        <= 5'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    delay_set_q <= tap_q;
                    cyc_q       <= 10'd0;
                    tap_fail_q  <= 1'b0;
                    state_q     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cyc_q == SETTLE_LAST) begin
                        cyc_q   <= 10'd0;
                        state_q <= S_SAMPLE;
`ifdef RGMII_DELAY_CAL_RDBK_CHECK_EN
                        if (bus.delay_set_rb != delay_set_q) begin
                            delay_set_q <= DEFAULT_TAP;
                            win_start_q <= 5'd0;
                            win_len_q   <= 6'd0;
                            busy_q      <= 1'b0;
                            fail_q      <= 1'b1;
                            state_q     <= S_FAIL;
                        end
`endif
                    end else begin
                        cyc_q <= cyc_q + 10'd1;
                    end
                end
                S_SAMPLE: begin
                    // Sampling always runs full length so every tap takes the same time.
                    if (!bus.pattern_ok) tap_fail_q <= 1'b1;
                    if (cyc_q == SAMPLE_LAST) begin
                        cyc_q   <= 10'd0;
                        state_q <= S_EVAL;
                    end else begin
                        cyc_q <= cyc_q + 10'd1;
                    end
                end
                S_EVAL: begin
                    run_start_q  <= run_start_d;
                    run_len_q    <= run_len_d;
                    best_start_q <= best_start_d;
                    best_len_q   <= best_len_d;
                    if (tap_q == 5'd31) begin
                        state_q <= S_CENTER;
                    end else begin
                        tap_q   <= tap_q + 5'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_CENTER: begin
                    win_start_q <= best_start_q;
                    win_len_q   <= best_len_q;
                    busy_q      <= 1'b0;
                    if (best_len_q == 6'd0) begin
                        delay_set_q <= DEFAULT_TAP;
                        fail_q      <= 1'b1;
                        state_q     <= S_FAIL;
                    end else begin
                        delay_set_q <= center_tap;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.delay_set = delay_set_q;
    assign bus.busy      = busy_q;
    assign bus.cal_done  = done_q;
    assign bus.cal_fail  = fail_q;
    assign bus.win_start = win_start_q;
    assign bus.win_len   = win_len_q;

endmodule

// File: tb/tb_rgmii_delay_cal.sv
// Bench for rgmii_delay_cal: tabled window cases, random masks against a window
// model, plus reset, mid-sweep start, restart and (optionally) readback abort.
module tb_rgmii_delay_cal;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgmii_delay_cal_if bus();

    rgmii_delay_cal dut (
        .delay_clk (clk),
        .delay_rst (rst),
        .bus       (bus)
    );

    logic [31:0] mask;
    int          drop_tap;
    bit          rb_force;
    int          same_cnt;
    logic [4:0]  last_ds;
    int          checks = 0;
    int          errors = 0;

    // pattern_ok follows the mask of the tap currently driven; drop_tap gets one
    // low cycle 40 cycles after its load (inside its sample window).
    always @(negedge clk) begin
        if (bus.delay_set != last_ds) same_cnt = 0;
        else same_cnt = same_cnt + 1;
        last_ds = bus.delay_set;
        bus.pattern_ok = mask[bus.delay_set] &&
                         !(drop_tap >= 0 && int'(bus.delay_set) == drop_tap && same_cnt == 40);
    end

    assign bus.delay_set_rb = (rb_force && bus.delay_set == 5'd3) ? 5'd0 : bus.delay_set;

    typedef struct {
        logic [31:0] m;
        int          drop;
        bit          poke;
        int          es;
        int          el;
        int          eset;
        bit          edone;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Longest strictly-longer run of passing taps; lowest tap wins ties.
    task automatic model(input logic [31:0] m, input int drop,
                         output int s, output int l, output int set);
        int rs, rl;
        s = 0; l = 0; rs = 0; rl = 0;
        for (int t = 0; t < 32; t++) begin
            if (m[t] && t != drop) begin
                if (rl == 0) rs = t;
                rl++;
                if (rl > l) begin
                    l = rl;
                    s = rs;
                end
            end else begin
                rl = 0;
            end
        end
        set = (l == 0) ? 0 : s + l / 2;
    endtask

    task automatic run_cal(input logic [31:0] m, input int drop, input bit poke, output int cyc);
        mask     = m;
        drop_tap = drop;
        @(posedge clk); #1 bus.cal_start = 1'b1;
        @(posedge clk); #1 bus.cal_start = 1'b0;
        chk("start_ack", int'({bus.busy, bus.cal_done, bus.cal_fail}), 4);
        cyc = 1;
        for (int i = 0; i < 3000 && bus.busy; i++) begin
            if (poke && i == 500) bus.cal_start = 1'b1;
            @(posedge clk); #1;
            bus.cal_start = 1'b0;
            if (bus.busy) cyc++;
        end
        if (bus.busy) chk("sweep_timeout", 1, 0);
    endtask

    task automatic chk_result(input string tag, input int es, input int el, input int eset, input bit edone);
        chk({tag, "_done"},  int'(bus.cal_done),  int'(edone));
        chk({tag, "_fail"},  int'(bus.cal_fail),  int'(!edone));
        chk({tag, "_busy"},  int'(bus.busy),      0);
        chk({tag, "_start"}, int'(bus.win_start), es);
        chk({tag, "_len"},   int'(bus.win_len),   el);
        chk({tag, "_set"},   int'(bus.delay_set), eset);
    endtask

    initial begin
        int cyc, es, el, eset;
        logic [31:0] rm;
        int rd;

        tbl[0] = '{32'h000F_FC00, -1, 1'b0, 10, 10, 15, 1'b1};
        tbl[1] = '{32'h00F0_003C, -1, 1'b0,  2,  4,  4, 1'b1};
        tbl[2] = '{32'hF000_0000, -1, 1'b0, 28,  4, 30, 1'b1};
        tbl[3] = '{32'hFFFF_FFFF, -1, 1'b0,  0, 32, 16, 1'b1};
        tbl[4] = '{32'h0000_0000, -1, 1'b0,  0,  0,  0, 1'b0};
        tbl[5] = '{32'h000F_FC00, 12, 1'b0, 13,  7, 16, 1'b1};
        tbl[6] = '{32'h000F_FC00, -1, 1'b1, 10, 10, 15, 1'b1};

        bus.cal_start = 1'b0;
        mask     = 32'h0;
        drop_tap = -1;
        rb_force = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_set",   int'(bus.delay_set), 0);
        chk("rst_busy",  int'(bus.busy),      0);
        chk("rst_done",  int'(bus.cal_done),  0);
        chk("rst_fail",  int'(bus.cal_fail),  0);
        chk("rst_wlen",  int'(bus.win_len),   0);

        for (int v = 0; v < 7; v++) begin
            run_cal(tbl[v].m, tbl[v].drop, tbl[v].poke, cyc);
            chk($sformatf("vec%0d_cycles", v), cyc, 2625);
            chk_result($sformatf("vec%0d", v), tbl[v].es, tbl[v].el, tbl[v].eset, tbl[v].edone);
        end

        for (int r = 0; r < 6; r++) begin
            rm = (r % 2 == 0) ? ($urandom & $urandom) : ($urandom | $urandom);
            rd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 31));
            model(rm, rd, es, el, eset);
            run_cal(rm, rd, 1'b0, cyc);
            chk($sformatf("rnd%0d_cycles", r), cyc, 2625);
            chk_result($sformatf("rnd%0d", r), es, el, eset, el != 0);
        end

`ifdef RGMII_DELAY_CAL_RDBK_CHECK_EN
        rb_force = 1'b1;
        run_cal(32'hFFFF_FFFF, -1, 1'b0, cyc);
        chk("rdbk_cycles", cyc, 3 * 82 + 1 + 16);
        chk_result("rdbk", 0, 0, 0, 1'b0);
        rb_force = 1'b0;
`endif

        mask = 32'hFFFF_FFFF;
        drop_tap = -1;
        @(posedge clk); #1 bus.cal_start = 1'b1;
        @(posedge clk); #1 bus.cal_start = 1'b0;
        for (int i = 0; i < 2000 && bus.delay_set != 5'd7; i++) @(posedge clk);
        chk("reach_tap7", int'(bus.delay_set), 7);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_set",   int'(bus.delay_set), 0);
        chk("midrst_busy",  int'(bus.busy),      0);
        chk("midrst_done",  int'(bus.cal_done),  0);
        chk("midrst_fail",  int'(bus.cal_fail),  0);
        chk("midrst_start", int'(bus.win_start), 0);
        chk("midrst_len",   int'(bus.win_len),   0);
        repeat (3000) @(posedge clk);
        #1;
        chk("idle_done", int'(bus.cal_done),  0);
        chk("idle_busy", int'(bus.busy),      0);
        chk("idle_set",  int'(bus.delay_set), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
